result_display: RTL and testbench

//   Downstream consumer of the calculator core. Captures the 8-bit result {Out_H,Out_L}

---
 rtl/result_display.sv | 200 ++++++++++++++++++++
 tb/tb_result_display.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// rtl/result_display.sv - Captures the calculator result, converts it to BCD and scans it onto a 4-digit 7-seg display.
// Optional hex display mode (extra hex_sel input) is enabled by defining DISP_HEX_EN.
module result_display #(
  parameter int REFRESH_BITS = 16,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Done,
`ifdef DISP_HEX_EN
  input  logic       hex_sel,
`endif
  input  logic [3:0] Out_H,
  input  logic [3:0] Out_L,
  output logic       busy,
  output logic       upd,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = (SEG_ACT_LOW != 0) ? 4'hF  : 4'h0;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic        load;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        hex_q, hex_d;
  logic        upd_q, upd_d;

  logic [11:0] bcd_adj;
  logic [19:0] dd_shift;

  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [1:0]  slot;
  logic [3:0]  digit;
  logic        lit;
  logic [6:0]  glyph;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'h0:    seg_glyph = 7'h3F;
      4'h1:    seg_glyph = 7'h06;
      4'h2:    seg_glyph = 7'h5B;
      4'h3:    seg_glyph = 7'h4F;
      4'h4:    seg_glyph = 7'h66;
      4'h5:    seg_glyph = 7'h6D;
      4'h6:    seg_glyph = 7'h7D;
      4'h7:    seg_glyph = 7'h07;
      4'h8:    seg_glyph = 7'h7F;
      4'h9:    seg_glyph = 7'h6F;
      4'hA:    seg_glyph = 7'h77;
      4'hB:    seg_glyph = 7'h7C;
      4'hC:    seg_glyph = 7'h39;
      4'hD:    seg_glyph = 7'h5E;
      4'hE:    seg_glyph = 7'h79;
      default: seg_glyph = 7'h71;
    endcase
  endfunction

  assign load = Done & ~done_q;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    dd_shift = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    hex_d   = hex_q;
    upd_d   = 1'b0;
    if (load) begin
      // A new load always wins, even over a conversion already in flight.
`ifdef DISP_HEX_EN
      if (hex_sel) begin
        state_d = IDLE;
        hund_d  = 4'd0;
        tens_d  = Out_H;
        ones_d  = Out_L;
        hex_d   = 1'b1;
        upd_d   = 1'b1;
      end else
`endif
      begin
        state_d = CONV;
        bin_d   = {Out_H, Out_L};
        bcd_d   = 12'd0;
        cnt_d   = 3'd0;
      end
    end else if (state_q == CONV) begin
      bin_d = dd_shift[7:0];
      bcd_d = dd_shift[19:8];
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d = IDLE;
        hund_d  = dd_shift[19:16];
        tens_d  = dd_shift[15:12];
        ones_d  = dd_shift[11:8];
        hex_d   = 1'b0;
        upd_d   = 1'b1;
      end
    end
  end

  assign slot   = scan_q[REFRESH_BITS-1 -: 2];
  assign scan_d = scan_q + REFRESH_BITS'(1);

  // Leading-zero blanking applies only to decimal; hex always shows both nibbles.
  always_comb begin
    digit = ones_q;
    lit   = 1'b1;
    case (slot)
      2'd0: begin
        digit = ones_q;
        lit   = 1'b1;
      end
      2'd1: begin
        digit = tens_q;
        lit   = hex_q | (hund_q != 4'd0) | (tens_q != 4'd0);
      end
      2'd2: begin
        digit = hund_q;
        lit   = ~hex_q & (hund_q != 4'd0);
      end
      default: begin
        digit = 4'd0;
        lit   = 1'b0;
      end
    endcase
    glyph = seg_glyph(digit);
    seg_d = lit ? glyph : 7'h00;
    an_d  = lit ? (4'b0001 << slot) : 4'b0000;
    if (SEG_ACT_LOW != 0) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bin_q   <= 8'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 3'd0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      hex_q   <= 1'b0;
      upd_q   <= 1'b0;
      scan_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      done_q  <= Done;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      hex_q   <= hex_d;
      upd_q   <= upd_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q == CONV);
  assign upd  = upd_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - Self-checking bench for result_display (table vectors, random values, corner sequences).
module tb_result_display;
  localparam int RB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Done;
  logic [3:0] Out_H;
  logic [3:0] Out_L;
  logic       busy;
  logic       upd;
  logic [6:0] seg;
  logic [3:0] an;
`ifdef DISP_HEX_EN
  logic       hex_sel;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_display #(.REFRESH_BITS(RB), .SEG_ACT_LOW(1)) dut (
    .clk(clk),
    .rst(rst),
    .Done(Done),
`ifdef DISP_HEX_EN
    .hex_sel(hex_sel),
`endif
    .Out_H(Out_H),
    .Out_L(Out_L),
    .busy(busy),
    .upd(upd),
    .seg(seg),
    .an(an)
  );

  typedef struct {
    logic [7:0] v;
    logic [2:0] mask;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive a load edge in cycle N, then record busy/upd for cycles N+1..N+15 (bit k = cycle N+k).
  task automatic load_track(input logic [7:0] v, input logic hex,
                            output logic [15:0] bv, output logic [15:0] uv);
    bv = '0;
    uv = '0;
    @(negedge clk);
    Done = 1'b1;
    {Out_H, Out_L} = v;
`ifdef DISP_HEX_EN
    hex_sel = hex;
`else
    if (hex) $display("hex load requested without hex support");
`endif
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      bv[k] = busy;
      uv[k] = upd;
      if (k == 1) Done = 1'b0;
    end
  endtask

  // Watch 64 cycles (four scan frames): each lit slot must appear 16 times with the right glyph.
  task automatic check_display(input string nm, input logic [2:0] mask,
                               input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    int cnt[3];
    int bad;
    logic [3:0] a;
    logic [6:0] s;
    logic [6:0] e;
    int idx;
    cnt = '{0, 0, 0};
    bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      a = ~an;
      s = ~seg;
      if (a != 4'b0000) begin
        if ($countones(a) != 1 || a[3]) begin
          bad++;
        end else begin
          idx = a[0] ? 0 : (a[1] ? 1 : 2);
          cnt[idx]++;
          e = (idx == 0) ? ref_glyph(int'(o)) : ((idx == 1) ? ref_glyph(int'(t)) : ref_glyph(int'(h)));
          if (s !== e) bad++;
        end
      end
    end
    check({nm, "_bad_slots"}, bad, 0);
    check({nm, "_ones_cnt"}, cnt[0], mask[0] ? 16 : 0);
    check({nm, "_tens_cnt"}, cnt[1], mask[1] ? 16 : 0);
    check({nm, "_hund_cnt"}, cnt[2], mask[2] ? 16 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bv, uv;
    int v, h, t, o, ucount, ucycle;

    tbl[0] = '{8'hFF, 3'b111, 4'd2, 4'd5, 4'd5};
    tbl[1] = '{8'h07, 3'b001, 4'd0, 4'd0, 4'd7};
    tbl[2] = '{8'h00, 3'b001, 4'd0, 4'd0, 4'd0};
    tbl[3] = '{8'h64, 3'b111, 4'd1, 4'd0, 4'd0};
    tbl[4] = '{8'h0A, 3'b011, 4'd0, 4'd1, 4'd0};
    tbl[5] = '{8'hC8, 3'b111, 4'd2, 4'd0, 4'd0};
    tbl[6] = '{8'h63, 3'b011, 4'd0, 4'd9, 4'd9};

    rst = 1'b1;
    Done = 1'b0;
    Out_H = 4'd0;
    Out_L = 4'd0;
`ifdef DISP_HEX_EN
    hex_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_upd", upd, 0);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    rst = 1'b0;
    check_display("rst_disp", 3'b001, 4'd0, 4'd0, 4'd0);

    for (int i = 0; i < 7; i++) begin
      load_track(tbl[i].v, 1'b0, bv, uv);
      check($sformatf("tbl%0d_busy", i), bv, 16'h01FE);
      check($sformatf("tbl%0d_upd", i), uv, 16'h0200);
      check_display($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].h, tbl[i].t, tbl[i].o);
    end

    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 255));
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      load_track(v[7:0], 1'b0, bv, uv);
      check($sformatf("rnd%0d_busy", i), bv, 16'h01FE);
      check($sformatf("rnd%0d_upd", i), uv, 16'h0200);
      check_display($sformatf("rnd%0d_v%0d", i, v), {h != 0, (h != 0) || (t != 0), 1'b1},
                    h[3:0], t[3:0], o[3:0]);
    end

    // 100 loaded, then 42 loaded four cycles later: only the 42 completes.
    bv = '0;
    uv = '0;
    @(negedge clk);
    Done = 1'b1;
    {Out_H, Out_L} = 8'h64;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      bv[k] = busy;
      uv[k] = upd;
      if (k == 1) Done = 1'b0;
      if (k == 4) begin
        Done = 1'b1;
        {Out_H, Out_L} = 8'h2A;
      end
      if (k == 5) Done = 1'b0;
    end
    check("abort_busy", bv, 16'h1FFE);
    check("abort_upd", uv, 16'h2000);
    check_display("abort", 3'b011, 4'd0, 4'd4, 4'd2);

    // Reset in the middle of converting 200.
    @(negedge clk);
    Done = 1'b1;
    {Out_H, Out_L} = 8'hC8;
    @(negedge clk);
    Done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    @(negedge clk);
    check("midrst_upd", upd, 0);
    rst = 1'b0;
    check_display("midrst", 3'b001, 4'd0, 4'd0, 4'd0);

    // Load 0 with Done held for 20 cycles: exactly one update.
    ucount = 0;
    ucycle = 0;
    @(negedge clk);
    Done = 1'b1;
    {Out_H, Out_L} = 8'h00;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (upd) begin
        ucount++;
        ucycle = k;
      end
      if (k == 20) Done = 1'b0;
    end
    check("hold_upd_count", ucount, 1);
    check("hold_upd_cycle", ucycle, 9);
    check_display("hold", 3'b001, 4'd0, 4'd0, 4'd0);

`ifdef DISP_HEX_EN
    load_track(8'hAB, 1'b1, bv, uv);
    hex_sel = 1'b0;
    check("hex_busy", bv, 16'h0000);
    check("hex_upd", uv, 16'h0002);
    check_display("hex", 3'b011, 4'd0, 4'hA, 4'hB);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
